// File: rtl/conv_1st_pool_if.sv
// rtl/conv_1st_pool_if.sv - row-in / pooled-row-out bundle for the first-layer max-pool stage
interface conv_1st_pool_if #(
    parameter int COLS     = 40,
    parameter int ROWS     = 40,
    parameter int CHANNELS = 32
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (ROWS > 3) ? $clog2(ROWS / 2) : 1;

    logic                    sta;
    logic                    valid_i;
    logic [COLS*8-1:0]       conv_i;
    logic [(COLS/2)*8-1:0]   pool_o;
    logic                    valid_o;
    logic [CW-1:0]           ch_o;
    logic [PW-1:0]           prow_o;
    logic                    last_o;
    logic                    busy_o;

    modport master (
        output sta, valid_i, conv_i,
        input  pool_o, valid_o, ch_o, prow_o, last_o, busy_o
    );

    modport slave (
        input  sta, valid_i, conv_i,
        output pool_o, valid_o, ch_o, prow_o, last_o, busy_o
    );
endinterface

// File: rtl/conv_1st_pool.sv
// rtl/conv_1st_pool.sv - 2x2 stride-2 max pool over full conv rows, channel-major frame tracking
module conv_1st_pool #(
    parameter int COLS     = 40,
    parameter int ROWS     = 40,
    parameter int CHANNELS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_1st_pool_if.slave bus
);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (ROWS > 3) ? $clog2(ROWS / 2) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    // Odd row closing the final pair; differs from LAST_ROW only when ROWS is odd
    localparam logic [RW-1:0] LAST_ODD = RW'(2 * (ROWS / 2) - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD} state_t;

    state_t                  state, state_n;
    logic [RW-1:0]           row_cnt, row_cnt_n;
    logic [CW-1:0]           ch_cnt, ch_cnt_n;
    logic                    latch_row, emit, emit_last, busy_n;
    logic [COLS*8-1:0]       row_buf;
    logic [(COLS/2)*8-1:0]   pooled;

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        pooled = '0;
        for (int j = 0; j < COLS / 2; j++) begin
            pooled[j*8 +: 8] = max2(max2(row_buf[16*j +: 8], row_buf[16*j+8 +: 8]),
                                    max2(bus.conv_i[16*j +: 8], bus.conv_i[16*j+8 +: 8]));
        end
    end

    always_comb begin
        state_n   = state;
        row_cnt_n = row_cnt;
        ch_cnt_n  = ch_cnt;
        latch_row = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        busy_n    = bus.busy_o;
        if (bus.sta) begin
            // A row arriving with sta is row 0 of channel 0
            busy_n   = 1'b1;
            ch_cnt_n = '0;
            if (bus.valid_i) begin
                latch_row = 1'b1;
                row_cnt_n = RW'(1);
                state_n   = S_ODD;
            end else begin
                row_cnt_n = '0;
                state_n   = S_EVEN;
            end
        end else if (bus.valid_i) begin
            case (state)
                S_EVEN: begin
                    if (row_cnt == LAST_ROW) begin
                        row_cnt_n = '0;
                        if (ch_cnt == LAST_CH) begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            ch_cnt_n = ch_cnt + 1'b1;
                        end
                    end else begin
                        latch_row = 1'b1;
                        row_cnt_n = row_cnt + 1'b1;
                        state_n   = S_ODD;
                    end
                end
                S_ODD: begin
                    emit      = 1'b1;
                    emit_last = (row_cnt == LAST_ODD) && (ch_cnt == LAST_CH);
                    state_n   = S_EVEN;
                    if (row_cnt == LAST_ROW) begin
                        row_cnt_n = '0;
                        if (ch_cnt == LAST_CH) begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            ch_cnt_n = ch_cnt + 1'b1;
                        end
                    end else begin
                        row_cnt_n = row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            ch_cnt      <= '0;
            row_buf     <= '0;
            bus.pool_o  <= '0;
            bus.valid_o <= 1'b0;
            bus.ch_o    <= '0;
            bus.prow_o  <= '0;
            bus.last_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
        end else begin
            state       <= state_n;
            row_cnt     <= row_cnt_n;
            ch_cnt      <= ch_cnt_n;
            bus.valid_o <= emit;
            bus.last_o  <= emit_last;
            bus.busy_o  <= busy_n;
            if (latch_row) begin
                row_buf <= bus.conv_i;
            end
            if (emit) begin
                bus.pool_o <= pooled;
                bus.ch_o   <= ch_cnt;
                bus.prow_o <= PW'(row_cnt >> 1);
            end
        end
    end
endmodule

// File: tb/tb_conv_1st_pool.sv
// tb/tb_conv_1st_pool.sv - randomized bench for conv_1st_pool against a row-count based pooling model
module tb_conv_1st_pool;
    localparam int COLS   = 40;
    localparam int ROWS_A = 40;
    localparam int CH_A   = 32;
    localparam int ROWS_B = 5;
    localparam int CH_B   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_1st_pool_if #(.COLS(COLS), .ROWS(ROWS_A), .CHANNELS(CH_A)) if0 ();
    conv_1st_pool_if #(.COLS(COLS), .ROWS(ROWS_B), .CHANNELS(CH_B)) if1 ();

    conv_1st_pool #(.COLS(COLS), .ROWS(ROWS_A), .CHANNELS(CH_A)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    conv_1st_pool #(.COLS(COLS), .ROWS(ROWS_B), .CHANNELS(CH_B)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    // Model: position in the frame is derived purely from the count of accepted rows
    bit                  m_armed [2];
    int                  m_n     [2];
    logic [COLS*8-1:0]   m_prev  [2];
    bit                  e_valid [2];
    bit                  e_last  [2];
    bit                  e_busy  [2];
    logic [COLS*4-1:0]   e_pool  [2];
    int                  e_ch    [2];
    int                  e_prow  [2];

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_armed[s] = 0; m_n[s] = 0; m_prev[s] = '0;
            e_valid[s] = 0; e_last[s] = 0; e_busy[s] = 0;
            e_pool[s] = '0; e_ch[s] = 0; e_prow[s] = 0;
        end
    endtask

    task automatic model_in(input int s, input bit sta, input bit vld, input logic [COLS*8-1:0] row);
        int rows, chs, r, c, mx;
        int v [4];
        rows = (s == 0) ? ROWS_A : ROWS_B;
        chs  = (s == 0) ? CH_A : CH_B;
        e_valid[s] = 0;
        e_last[s]  = 0;
        if (sta) begin
            m_armed[s] = 1; m_n[s] = 0; e_busy[s] = 1;
        end
        if (vld && m_armed[s]) begin
            r = m_n[s] % rows;
            c = m_n[s] / rows;
            if (r % 2 == 1) begin
                e_valid[s] = 1;
                e_ch[s]    = c;
                e_prow[s]  = r / 2;
                e_last[s]  = (c == chs - 1) && (r / 2 == rows / 2 - 1);
                for (int j = 0; j < COLS / 2; j++) begin
                    v[0] = int'(m_prev[s][(2*j)*8 +: 8]);
                    v[1] = int'(m_prev[s][(2*j+1)*8 +: 8]);
                    v[2] = int'(row[(2*j)*8 +: 8]);
                    v[3] = int'(row[(2*j+1)*8 +: 8]);
                    mx = 0;
                    for (int q = 0; q < 4; q++) if (v[q] > mx) mx = v[q];
                    e_pool[s][j*8 +: 8] = 8'(mx);
                end
            end else begin
                m_prev[s] = row;
            end
            m_n[s]++;
            if (m_n[s] == rows * chs) begin
                m_armed[s] = 0; e_busy[s] = 0;
            end
        end
    endtask

    task automatic step(input int s, input bit sta, input bit vld, input logic [COLS*8-1:0] row);
        @(negedge clk);
        if (s == 0) begin
            if0.sta = sta; if0.valid_i = vld; if0.conv_i = row;
            if1.sta = 0;   if1.valid_i = 0;   if1.conv_i = '0;
        end else begin
            if1.sta = sta; if1.valid_i = vld; if1.conv_i = row;
            if0.sta = 0;   if0.valid_i = 0;   if0.conv_i = '0;
        end
        model_in(s, sta, vld, row);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS*8-1:0] rand_row(input int lo);
        logic [COLS*8-1:0] r;
        for (int k = 0; k < COLS; k++) r[k*8 +: 8] = 8'($urandom_range(lo, 255));
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if0.valid_o, if0.last_o, if0.busy_o, if1.valid_o, if1.busy_o} !== 5'b0 ||
            if0.pool_o !== '0 || if0.ch_o !== '0 || if0.prow_o !== '0) begin
            errors++;
            $display("FAIL reset: v=%b l=%b b=%b pool=%h ch=%0d prow=%0d, want all zero",
                     if0.valid_o, if0.last_o, if0.busy_o, if0.pool_o, if0.ch_o, if0.prow_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [COLS*8-1:0] a, b;
        logic [COLS*4-1:0] want;
        for (int k = 0; k < COLS; k++) begin
            a[k*8 +: 8] = 8'(k);
            b[k*8 +: 8] = 8'(k + 50);
        end
        step(0, 1, 0, '0);
        step(0, 0, 1, a);
        step(0, 0, 1, b);
        for (int j = 0; j < COLS / 2; j++) want[j*8 +: 8] = 8'(2 * j + 51);
        checks++;
        if (if0.pool_o !== want || if0.valid_o !== 1'b1 || if0.ch_o !== '0 || if0.prow_o !== '0) begin
            errors++;
            $display("FAIL directed_ramp: v=%b ch=%0d prow=%0d pool=%h, want v=1 ch=0 prow=0 pool=%h",
                     if0.valid_o, if0.ch_o, if0.prow_o, if0.pool_o, want);
        end
        for (int k = 0; k < COLS; k++) a[k*8 +: 8] = (k == 3) ? 8'h00 : 8'h7F;
        step(0, 0, 1, a);
        step(0, 0, 1, '0);
        want = {(COLS/2){8'h7F}};
        checks++;
        if (if0.pool_o !== want || if0.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL directed_7f: v=%b pool=%h, want v=1 pool=%h", if0.valid_o, if0.pool_o, want);
        end
        b = '0;
        b[5*8 +: 8] = 8'h12;
        step(0, 0, 1, '0);
        step(0, 0, 1, b);
        want = '0;
        want[2*8 +: 8] = 8'h12;
        checks++;
        if (if0.pool_o !== want || 32'(if0.prow_o) !== 32'd2 || 32'(if0.prow_o) !== e_prow[0]) begin
            errors++;
            $display("FAIL directed_lane2: prow=%0d pool=%h, want prow=2 pool=%h", if0.prow_o, if0.pool_o, want);
        end
        step(0, 0, 0, '0);
        checks++;
        if (if0.valid_o !== 1'b0 || if0.pool_o !== want || if0.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL directed_hold: v=%b b=%b pool=%h, want v=0 b=1 pool=%h",
                     if0.valid_o, if0.busy_o, if0.pool_o, want);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid = 0, nlast = 0, last_at = -1;
        step(0, 1, 0, '0);
        for (int i = 0; i < ROWS_A * CH_A; i++) begin
            step(0, 0, 1, rand_row(0));
            if (if0.valid_o === 1'b1) nvalid++;
            if (if0.last_o === 1'b1) begin nlast++; last_at = nvalid; end
            checks++;
            if ({if0.valid_o, if0.last_o, if0.busy_o} !== {e_valid[0], e_last[0], e_busy[0]} ||
                if0.pool_o !== e_pool[0] || 32'(if0.ch_o) !== e_ch[0] || 32'(if0.prow_o) !== e_prow[0]) begin
                errors++;
                $display("FAIL b2b row %0d: vlb=%b%b%b ch=%0d prow=%0d pool=%h, want vlb=%b%b%b ch=%0d prow=%0d pool=%h",
                         i, if0.valid_o, if0.last_o, if0.busy_o, if0.ch_o, if0.prow_o, if0.pool_o,
                         e_valid[0], e_last[0], e_busy[0], e_ch[0], e_prow[0], e_pool[0]);
            end
        end
        step(0, 0, 0, '0);
        checks++;
        if (nvalid != 640 || nlast != 1 || last_at != 640 || if0.busy_o !== 1'b0 || if0.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_totals: valid=%0d last=%0d last_at=%0d busy=%b, want 640 1 640 0",
                     nvalid, nlast, last_at, if0.busy_o);
        end
    endtask

    task automatic test_random_gaps();
        step(0, 1, 0, '0);
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), rand_row(0));
            checks++;
            if ({if0.valid_o, if0.last_o, if0.busy_o} !== {e_valid[0], e_last[0], e_busy[0]} ||
                if0.pool_o !== e_pool[0] || 32'(if0.ch_o) !== e_ch[0] || 32'(if0.prow_o) !== e_prow[0]) begin
                errors++;
                $display("FAIL gaps cyc %0d: vlb=%b%b%b ch=%0d prow=%0d pool=%h, want vlb=%b%b%b ch=%0d prow=%0d pool=%h",
                         i, if0.valid_o, if0.last_o, if0.busy_o, if0.ch_o, if0.prow_o, if0.pool_o,
                         e_valid[0], e_last[0], e_busy[0], e_ch[0], e_prow[0], e_pool[0]);
            end
        end
    endtask

    task automatic test_odd_rows();
        int nvalid = 0;
        step(1, 1, 0, '0);
        for (int i = 0; i < ROWS_B * CH_B; i++) begin
            step(1, 0, 1, rand_row(0));
            if (if1.valid_o === 1'b1) nvalid++;
            checks++;
            if ({if1.valid_o, if1.last_o, if1.busy_o} !== {e_valid[1], e_last[1], e_busy[1]} ||
                if1.pool_o !== e_pool[1] || 32'(if1.ch_o) !== e_ch[1] || 32'(if1.prow_o) !== e_prow[1]) begin
                errors++;
                $display("FAIL odd_rows row %0d: vlb=%b%b%b ch=%0d prow=%0d pool=%h, want vlb=%b%b%b ch=%0d prow=%0d pool=%h",
                         i, if1.valid_o, if1.last_o, if1.busy_o, if1.ch_o, if1.prow_o, if1.pool_o,
                         e_valid[1], e_last[1], e_busy[1], e_ch[1], e_prow[1], e_pool[1]);
            end
        end
        checks++;
        if (nvalid != 4 || if1.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL odd_rows_totals: valid=%0d busy=%b, want 4 0", nvalid, if1.busy_o);
        end
    endtask

    task automatic test_abort();
        step(0, 1, 0, '0);
        step(0, 0, 1, rand_row(200));
        step(0, 1, 0, '0);
        step(0, 0, 1, rand_row(0));
        checks++;
        if (if0.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_output: v=%b, want 0", if0.valid_o);
        end
        step(0, 0, 1, rand_row(0));
        step(0, 1, 1, rand_row(0));
        step(0, 0, 1, rand_row(0));
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({if0.valid_o, if0.last_o, if0.busy_o} !== {e_valid[0], e_last[0], e_busy[0]} ||
                if0.pool_o !== e_pool[0] || 32'(if0.ch_o) !== e_ch[0] || 32'(if0.prow_o) !== e_prow[0] ||
                if0.ch_o !== '0 || if0.prow_o !== '0) begin
                errors++;
                $display("FAIL abort step %0d: vlb=%b%b%b ch=%0d prow=%0d pool=%h, want vlb=%b%b%b ch=0 prow=0 pool=%h",
                         i, if0.valid_o, if0.last_o, if0.busy_o, if0.ch_o, if0.prow_o, if0.pool_o,
                         e_valid[0], e_last[0], e_busy[0], e_pool[0]);
            end
            step(0, 0, 0, '0);
        end
    endtask

    task automatic test_idle_and_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, rand_row(0));
            checks++;
            if (if1.valid_o !== 1'b0 || if1.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: v=%b b=%b, want 0 0", if1.valid_o, if1.busy_o);
            end
        end
        step(0, 1, 0, '0);
        step(0, 0, 1, rand_row(1));
        step(0, 0, 1, rand_row(1));
        step(0, 0, 1, rand_row(1));
        @(negedge clk);
        if0.valid_i = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if ({if0.valid_o, if0.last_o, if0.busy_o} !== 3'b0 || if0.pool_o !== '0 ||
            if0.ch_o !== '0 || if0.prow_o !== '0) begin
            errors++;
            $display("FAIL async_reset: vlb=%b%b%b pool=%h ch=%0d prow=%0d, want all zero",
                     if0.valid_o, if0.last_o, if0.busy_o, if0.pool_o, if0.ch_o, if0.prow_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, rand_row(0));
            checks++;
            if (if0.valid_o !== 1'b0 || if0.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: v=%b b=%b, want 0 0", if0.valid_o, if0.busy_o);
            end
        end
        step(0, 1, 0, '0);
        step(0, 0, 1, rand_row(0));
        step(0, 0, 1, rand_row(0));
        checks++;
        if ({if0.valid_o, if0.busy_o} !== 2'b11 || if0.pool_o !== e_pool[0] ||
            if0.ch_o !== '0 || if0.prow_o !== '0) begin
            errors++;
            $display("FAIL restart: vb=%b%b ch=%0d prow=%0d pool=%h, want vb=11 ch=0 prow=0 pool=%h",
                     if0.valid_o, if0.busy_o, if0.ch_o, if0.prow_o, if0.pool_o, e_pool[0]);
        end
    endtask

    initial begin
        if0.sta = 0; if0.valid_i = 0; if0.conv_i = '0;
        if1.sta = 0; if1.valid_i = 0; if1.conv_i = '0;
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_gaps();
        test_odd_rows();
        test_abort();
        test_idle_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
